// File: rtl/gemm_kloop_array.sv
// Parametrised k-looped GEMM tile engine: C = sum over k-tiles of A_t * B_t,
// with ready/valid operand intake and a held, handshaked result.
module gemm_kloop_array #(
    parameter int unsigned MESH_ROW = 8,
    parameter int unsigned MESH_COL = 8,
    parameter int unsigned TILE_K   = 8,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               io_start_do,
    input  logic [CNT_W-1:0]                   io_cfg_k,
    input  logic                               io_cfg_signed,
    output logic                               io_busy,
    input  logic                               io_data_in_valid,
    output logic                               io_data_in_ready,
    input  logic [MESH_ROW*TILE_K*IN_W-1:0]    io_a_io_in,
    input  logic [TILE_K*MESH_COL*IN_W-1:0]    io_b_io_in,
    output logic                               io_data_out_valid,
    input  logic                               io_data_out_ready,
    output logic [MESH_ROW*MESH_COL*ACC_W-1:0] io_c_io_out,
    output logic                               io_done
);

    localparam int unsigned N_ACC = MESH_ROW * MESH_COL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cfg_k_q, cfg_k_d;
    logic               sgn_q, sgn_d;
    logic               done_d;
    logic [ACC_W-1:0]   acc_q   [N_ACC];
    logic [ACC_W-1:0]   acc_d   [N_ACC];
    logic [ACC_W-1:0]   acc_sum [N_ACC];

    // Sign- or zero-extend one operand element to accumulator width
    function automatic logic [ACC_W-1:0] ext(input logic [IN_W-1:0] x, input logic sgn);
        return {{(ACC_W-IN_W){sgn & x[IN_W-1]}}, x};
    endfunction

    // Accumulator plus one beat's worth of dot products; wraps mod 2^ACC_W
    always_comb begin
        for (int unsigned m = 0; m < MESH_ROW; m++) begin
            for (int unsigned n = 0; n < MESH_COL; n++) begin
                logic [ACC_W-1:0] s;
                s = acc_q[m*MESH_COL+n];
                for (int unsigned k = 0; k < TILE_K; k++) begin
                    s = s + ext(io_a_io_in[(m*TILE_K+k)*IN_W +: IN_W], sgn_q)
                          * ext(io_b_io_in[(n*TILE_K+k)*IN_W +: IN_W], sgn_q);
                end
                acc_sum[m*MESH_COL+n] = s;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_k_d = cfg_k_q;
        sgn_d   = sgn_q;
        done_d  = 1'b0;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (io_start_do) begin
                    state_d = ACC;
                    cnt_d   = '0;
                    cfg_k_d = (io_cfg_k == '0) ? CNT_W'(1) : io_cfg_k;
                    sgn_d   = io_cfg_signed;
                    for (int unsigned i = 0; i < N_ACC; i++) acc_d[i] = '0;
                end
            end
            ACC: begin
                if (io_data_in_valid) begin
                    acc_d = acc_sum;
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    if (CNT_W'(cnt_q + CNT_W'(1)) == cfg_k_q) state_d = HOLD;
                end
            end
            HOLD: begin
                if (io_data_out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            cfg_k_q           <= '0;
            sgn_q             <= 1'b0;
            io_busy           <= 1'b0;
            io_data_in_ready  <= 1'b0;
            io_data_out_valid <= 1'b0;
            io_done           <= 1'b0;
            for (int unsigned i = 0; i < N_ACC; i++) acc_q[i] <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            cfg_k_q           <= cfg_k_d;
            sgn_q             <= sgn_d;
            io_busy           <= (state_d != IDLE);
            io_data_in_ready  <= (state_d == ACC);
            io_data_out_valid <= (state_d == HOLD);
            io_done           <= done_d;
            for (int unsigned i = 0; i < N_ACC; i++) acc_q[i] <= acc_d[i];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_ACC; i++) io_c_io_out[i*ACC_W +: ACC_W] = acc_q[i];
    end

endmodule
